rv32imf_apu_disp: RTL and testbench
===================================

RV32IMF_APU_DISP -- requirements
Module: rv32imf_apu_disp

Interface
REQ-001 SHALL have parameter DEPTH, default 2, in-flight op limit (power of 2, 2..8).
REQ-002 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports enable_i in 1, op_i in 6, operands_i in 3x32, flags_i in 15, waddr_i in 6: upstream op request and destination register (bit5=FP file).
REQ-005 SHALL have ports rs_addr_i in 3x6 and rs_valid_i in 3: source registers of the op in decode, for hazard check.
REQ-006 SHALL have ports ready_o out 1 (op accepted when enable_i&ready_o) and stall_o out 1 (hazard).
REQ-007 SHALL have ports apu_req_o out 1, apu_gnt_i in 1, apu_operands_o out 3x32, apu_op_o out 6, apu_flags_o out 15: FPU request side.
REQ-008 SHALL have ports apu_rvalid_i in 1, apu_rdata_i in 32, apu_rflags_i in 5: FPU result side.
REQ-009 SHALL have ports wb_valid_o out 1, wb_waddr_o out 6, wb_rdata_o out 32, wb_rflags_o out 5: writeback.
REQ-010 SHALL have ports busy_o out 1 (count!=0 or pending) and err_o out 1 (sticky).

Function
REQ-011 Accept = enable_i & ready_o; on accept, op/operands/flags SHALL load a pending register and pend_q SHALL set next cycle.
REQ-012 apu_req_o SHALL equal pend_q; apu_operands_o/op_o/flags_o SHALL come from the pending register and stay stable while pend_q & !apu_gnt_i.
REQ-013 pend_q SHALL clear on pend_q & apu_gnt_i without same-cycle accept; gnt and accept together SHALL reload it (back-to-back issue, one op per cycle).
REQ-014 Tag FIFO SHALL push waddr_i on accept and pop on apu_rvalid_i; cnt = FIFO occupancy, 0..DEPTH.
REQ-015 ready_o = (!pend_q | apu_gnt_i) & (cnt<DEPTH | apu_rvalid_i) & !stall_o.
REQ-016 stall_o SHALL assert when any rs_valid_i[k] source equals a valid FIFO entry waddr or wb_waddr_o while wb_valid_o.
REQ-017 Latency: accept in cycle N gives apu_req_o in N+1; apu_rvalid_i in cycle M gives wb_valid_o in M+1 with wb_waddr_o = FIFO head at M, rdata/rflags registered.
REQ-018 wb_valid_o SHALL be a one-cycle pulse per apu_rvalid_i; no back-pressure on writeback.
REQ-019 Simultaneous push and pop SHALL leave cnt unchanged; pointers wrap modulo DEPTH.
REQ-020 apu_rvalid_i with cnt==0 and no same-cycle push SHALL set err_o, be dropped (no wb_valid_o), and leave cnt at 0.
REQ-021 Results SHALL be attributed in FIFO (issue) order.

Reset
REQ-022 rst_ni low SHALL asynchronously clear pend_q, cnt, pointers, wb_valid_o, err_o; all outputs 0 (ready_o=1 unless stall_o).
REQ-023 Reset mid-operation SHALL discard pending and in-flight ops; results returning after reset fall under REQ-020.

Structure
REQ-024 rv32imf_pkg SHALL hold APU_NARGS=3, APU_WOP=6, APU_NDSFLAGS=15, APU_NUSFLAGS=5, REGADDR_W=6 and an apu request struct typedef.
REQ-025 Tag FIFO SHALL be sub-module rv32imf_apu_tag_fifo (push/pop/full/empty, entries exposed for hazard compare).
REQ-026 apu_* ports SHALL connect directly to the FP wrapper apu_* ports.

Verification
REQ-027 Single op, waddr=0x21, gnt immediate, rvalid 3 cycles later -> req_o 1 cycle, wb_valid_o 1 cycle with waddr 0x21.
REQ-028 gnt held low 4 cycles -> apu_req_o stays high, operands stable, ready_o=0, single issue on grant.
REQ-029 DEPTH=2, issue 0x21,0x22, no rvalid -> ready_o=0 on third; rvalid same cycle as third accept -> accepted, cnt stays 2, wb waddr 0x21 then 0x22.
REQ-030 In flight 0x25, decode rs_addr_i[1]=0x25 valid -> stall_o=1 until cycle after wb of 0x25.
REQ-031 apu_rvalid_i with empty FIFO -> err_o=1 sticky, no wb_valid_o.
REQ-032 rst_ni low with 2 in flight and pend_q set -> busy_o=0, apu_req_o=0 immediately, cnt=0.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// Shared widths and the APU request bundle for the RV32IMF FP dispatch path.
package rv32imf_pkg;
  localparam int unsigned APU_NARGS    = 3;
  localparam int unsigned APU_WOP      = 6;
  localparam int unsigned APU_NDSFLAGS = 15;
  localparam int unsigned APU_NUSFLAGS = 5;
  localparam int unsigned REGADDR_W    = 6;
  localparam int unsigned DATA_W       = 32;

  typedef struct packed {
    logic [APU_WOP-1:0]                 op;
    logic [APU_NARGS-1:0][DATA_W-1:0]   operands;
    logic [APU_NDSFLAGS-1:0]            flags;
  } apu_req_t;
endpackage

// File: rtl/rv32imf_apu_tag_fifo.sv
// Destination-register tag FIFO for in-flight APU ops; all entries are exposed for hazard checks.
module rv32imf_apu_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          entry_valid
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [PW:0]             cnt_q;
  logic                    do_push, do_pop;
  logic [PW-1:0]           off;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & (cnt_q != '0);
  assign do_push = push & ((cnt_q != FULL_CNT) | do_pop);

  assign head    = mem_q[rptr_q];
  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign entries = mem_q;

  always_comb begin
    off         = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rptr_q;
      entry_valid[i] = ({1'b0, off} < cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/rv32imf_apu_disp.sv
// APU dispatcher: holds one pending FPU request, tracks in-flight destinations, and registers writeback.
import rv32imf_pkg::*;

module rv32imf_apu_disp #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 enable_i,
  input  logic [APU_WOP-1:0]                   op_i,
  input  logic [APU_NARGS-1:0][DATA_W-1:0]     operands_i,
  input  logic [APU_NDSFLAGS-1:0]              flags_i,
  input  logic [REGADDR_W-1:0]                 waddr_i,
  input  logic [APU_NARGS-1:0][REGADDR_W-1:0]  rs_addr_i,
  input  logic [APU_NARGS-1:0]                 rs_valid_i,
  output logic                                 ready_o,
  output logic                                 stall_o,
  output logic                                 apu_req_o,
  input  logic                                 apu_gnt_i,
  output logic [APU_NARGS-1:0][DATA_W-1:0]     apu_operands_o,
  output logic [APU_WOP-1:0]                   apu_op_o,
  output logic [APU_NDSFLAGS-1:0]              apu_flags_o,
  input  logic                                 apu_rvalid_i,
  input  logic [DATA_W-1:0]                    apu_rdata_i,
  input  logic [APU_NUSFLAGS-1:0]              apu_rflags_i,
  output logic                                 wb_valid_o,
  output logic [REGADDR_W-1:0]                 wb_waddr_o,
  output logic [DATA_W-1:0]                    wb_rdata_o,
  output logic [APU_NUSFLAGS-1:0]              wb_rflags_o,
  output logic                                 busy_o,
  output logic                                 err_o
);
  // Handshakes: upstream transfers when enable_i & ready_o; the FPU takes the
  // request when apu_req_o & apu_gnt_i, and the request is held stable until then.
  // Results (apu_rvalid_i) and writeback (wb_valid_o) are single-cycle pulses with no back-pressure.

  apu_req_t                          req_q;
  logic                              pend_q;
  logic                              accept, rvalid_ok, fifo_push, fifo_pop;
  logic                              fifo_full, fifo_empty, stall;
  logic [REGADDR_W-1:0]              head_waddr;
  logic [DEPTH-1:0][REGADDR_W-1:0]   tag_entries;
  logic [DEPTH-1:0]                  tag_valid;

  assign accept    = enable_i & ready_o;
  // A result with an empty FIFO is only attributable to an op entering this very cycle.
  assign rvalid_ok = apu_rvalid_i & (!fifo_empty | accept);
  assign fifo_pop  = apu_rvalid_i & !fifo_empty;
  assign fifo_push = accept & !(fifo_empty & apu_rvalid_i);

  assign ready_o = (!pend_q | apu_gnt_i) & (!fifo_full | apu_rvalid_i) & !stall_o;
  assign stall_o = stall;
  assign busy_o  = pend_q | !fifo_empty;

  assign apu_req_o      = pend_q;
  assign apu_op_o       = req_q.op;
  assign apu_operands_o = req_q.operands;
  assign apu_flags_o    = req_q.flags;

  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < APU_NARGS; k++) begin
      if (rs_valid_i[k]) begin
        if (wb_valid_o && (wb_waddr_o == rs_addr_i[k])) stall = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          if (tag_valid[e] && (tag_entries[e] == rs_addr_i[k])) stall = 1'b1;
        end
      end
    end
  end

  rv32imf_apu_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (REGADDR_W)
  ) u_tag_fifo (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .wdata       (waddr_i),
    .head        (head_waddr),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entries     (tag_entries),
    .entry_valid (tag_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else if (accept) begin
      pend_q         <= 1'b1;
      req_q.op       <= op_i;
      req_q.operands <= operands_i;
      req_q.flags    <= flags_i;
    end else if (apu_gnt_i) begin
      pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o  <= 1'b0;
      wb_waddr_o  <= '0;
      wb_rdata_o  <= '0;
      wb_rflags_o <= '0;
      err_o       <= 1'b0;
    end else begin
      wb_valid_o <= rvalid_ok;
      if (rvalid_ok) wb_waddr_o <= fifo_empty ? waddr_i : head_waddr;
      if (apu_rvalid_i) begin
        wb_rdata_o  <= apu_rdata_i;
        wb_rflags_o <= apu_rflags_i;
      end
      if (apu_rvalid_i && !rvalid_ok) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rv32imf_apu_disp.sv
// Directed bench for rv32imf_apu_disp: issue, grant stalls, full FIFO, hazards, error and reset.
module tb_rv32imf_apu_disp;
  logic              clk = 1'b0;
  logic              rst_ni;
  logic              enable;
  logic [5:0]        op;
  logic [2:0][31:0]  operands;
  logic [14:0]       flags;
  logic [5:0]        waddr;
  logic [2:0][5:0]   rs_addr;
  logic [2:0]        rs_valid;
  logic              ready_o, stall_o, apu_req_o;
  logic              gnt;
  logic [2:0][31:0]  apu_operands_o;
  logic [5:0]        apu_op_o;
  logic [14:0]       apu_flags_o;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [4:0]        rflags;
  logic              wb_valid_o;
  logic [5:0]        wb_waddr_o;
  logic [31:0]       wb_rdata_o;
  logic [4:0]        wb_rflags_o;
  logic              busy_o, err_o;

  int checks = 0;
  int errors = 0;

  rv32imf_apu_disp #(.DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .enable_i       (enable),
    .op_i           (op),
    .operands_i     (operands),
    .flags_i        (flags),
    .waddr_i        (waddr),
    .rs_addr_i      (rs_addr),
    .rs_valid_i     (rs_valid),
    .ready_o        (ready_o),
    .stall_o        (stall_o),
    .apu_req_o      (apu_req_o),
    .apu_gnt_i      (gnt),
    .apu_operands_o (apu_operands_o),
    .apu_op_o       (apu_op_o),
    .apu_flags_o    (apu_flags_o),
    .apu_rvalid_i   (rvalid),
    .apu_rdata_i    (rdata),
    .apu_rflags_i   (rflags),
    .wb_valid_o     (wb_valid_o),
    .wb_waddr_o     (wb_waddr_o),
    .wb_rdata_o     (wb_rdata_o),
    .wb_rflags_o    (wb_rflags_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks run 1ns later, well clear of the rising edge.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; enable = 1'b0; op = '0; operands = '0; flags = '0; waddr = '0;
    rs_addr = '0; rs_valid = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; rflags = '0;
    #2;
    checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", apu_req_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    checks++; if ({wb_valid_o, err_o, stall_o} !== 3'b000) begin errors++; $display("FAIL reset_wb_err_stall: got %b exp 000", {wb_valid_o, err_o, stall_o}); end
    next_cyc(); rst_ni = 1'b1;
    next_cyc();
  endtask

  task automatic test_single();
    next_cyc(); enable = 1'b1; waddr = 6'h21; op = 6'h0a; flags = 15'h1234;
    operands = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001}; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", ready_o); end
    next_cyc(); enable = 1'b0; gnt = 1'b1; #1;
    checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL single_req: got %b exp 1", apu_req_o); end
    checks++; if (apu_op_o !== 6'h0a) begin errors++; $display("FAIL single_op: got %h exp 0a", apu_op_o); end
    checks++; if (apu_operands_o !== {32'h0000_0003, 32'h0000_0002, 32'h0000_0001}) begin errors++; $display("FAIL single_operands: got %h", apu_operands_o); end
    checks++; if (apu_flags_o !== 15'h1234) begin errors++; $display("FAIL single_flags: got %h exp 1234", apu_flags_o); end
    next_cyc(); gnt = 1'b0; #1;
    checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b exp 0", apu_req_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_inflight: got %b exp 1", busy_o); end
    next_cyc();
    next_cyc(); rvalid = 1'b1; rdata = 32'hcafe_0001; rflags = 5'h03; #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_wb_early: got %b exp 0", wb_valid_o); end
    next_cyc(); rvalid = 1'b0; #1;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b exp 1", wb_valid_o); end
    checks++; if (wb_waddr_o !== 6'h21) begin errors++; $display("FAIL single_wb_waddr: got %h exp 21", wb_waddr_o); end
    checks++; if (wb_rdata_o !== 32'hcafe_0001) begin errors++; $display("FAIL single_wb_rdata: got %h exp cafe0001", wb_rdata_o); end
    checks++; if (wb_rflags_o !== 5'h03) begin errors++; $display("FAIL single_wb_rflags: got %h exp 03", wb_rflags_o); end
    next_cyc(); #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_wb_pulse: got %b exp 0", wb_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_gnt_hold();
    next_cyc(); enable = 1'b1; waddr = 6'h30; op = 6'h11; flags = 15'h0abc;
    operands = {32'hbbbb_0003, 32'hbbbb_0002, 32'hbbbb_0001}; gnt = 1'b0;
    next_cyc(); waddr = 6'h31; op = 6'h12; flags = 15'h7fff; operands = {32'h1, 32'h2, 32'h3};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL hold_req[%0d]: got %b exp 1", i, apu_req_o); end
      checks++; if (apu_operands_o !== {32'hbbbb_0003, 32'hbbbb_0002, 32'hbbbb_0001} || apu_op_o !== 6'h11 || apu_flags_o !== 15'h0abc) begin errors++; $display("FAIL hold_stable[%0d]: got op %h flags %h operands %h", i, apu_op_o, apu_flags_o, apu_operands_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b exp 0", i, ready_o); end
      next_cyc();
    end
    enable = 1'b0; gnt = 1'b1; #1;
    checks++; if (apu_req_o !== 1'b1) begin errors++; $display("FAIL hold_grant_req: got %b exp 1", apu_req_o); end
    next_cyc(); gnt = 1'b0; #1;
    checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL hold_single_issue: got %b exp 0", apu_req_o); end
    next_cyc(); rvalid = 1'b1; rdata = 32'h0000_5a5a; rflags = 5'h10;
    next_cyc(); rvalid = 1'b0; #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_waddr_o !== 6'h30) begin errors++; $display("FAIL hold_wb: got valid %b waddr %h exp 1 30", wb_valid_o, wb_waddr_o); end
    next_cyc(); #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hold_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    next_cyc(); enable = 1'b1; waddr = 6'h21; gnt = 1'b0; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b exp 1", ready_o); end
    next_cyc(); waddr = 6'h22; gnt = 1'b1; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b exp 1", ready_o); end
    next_cyc(); waddr = 6'h23; #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b exp 0", ready_o); end
    next_cyc(); rvalid = 1'b1; rdata = 32'h0000_0a21; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_pop_push_ready: got %b exp 1", ready_o); end
    next_cyc(); enable = 1'b0; rvalid = 1'b0; #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_waddr_o !== 6'h21 || wb_rdata_o !== 32'h0000_0a21) begin errors++; $display("FAIL b2b_wb1: got valid %b waddr %h data %h", wb_valid_o, wb_waddr_o, wb_rdata_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_cnt_still_full: got %b exp 0", ready_o); end
    next_cyc(); rvalid = 1'b1; rdata = 32'h0000_0a22; #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_wb_gap: got %b exp 0", wb_valid_o); end
    next_cyc(); rdata = 32'h0000_0a23; #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_waddr_o !== 6'h22 || wb_rdata_o !== 32'h0000_0a22) begin errors++; $display("FAIL b2b_wb2: got valid %b waddr %h data %h", wb_valid_o, wb_waddr_o, wb_rdata_o); end
    next_cyc(); rvalid = 1'b0; #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_waddr_o !== 6'h23 || wb_rdata_o !== 32'h0000_0a23) begin errors++; $display("FAIL b2b_wb3: got valid %b waddr %h data %h", wb_valid_o, wb_waddr_o, wb_rdata_o); end
    next_cyc(); gnt = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b wb %b exp 0 0", busy_o, wb_valid_o); end
  endtask

  task automatic test_hazard();
    next_cyc(); enable = 1'b1; waddr = 6'h25;
    next_cyc(); enable = 1'b0; gnt = 1'b1; rs_addr = {6'h00, 6'h25, 6'h05}; rs_valid = 3'b010; #1;
    checks++; if (stall_o !== 1'b1 || ready_o !== 1'b0) begin errors++; $display("FAIL haz_stall: got stall %b ready %b exp 1 0", stall_o, ready_o); end
    next_cyc(); gnt = 1'b0; rs_valid = 3'b001; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL haz_invalid_src: got %b exp 0", stall_o); end
    next_cyc(); rs_valid = 3'b010; rvalid = 1'b1; #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL haz_stall_at_rvalid: got %b exp 1", stall_o); end
    next_cyc(); rvalid = 1'b0; #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_waddr_o !== 6'h25) begin errors++; $display("FAIL haz_wb: got valid %b waddr %h exp 1 25", wb_valid_o, wb_waddr_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL haz_stall_at_wb: got %b exp 1", stall_o); end
    next_cyc(); #1;
    checks++; if (stall_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL haz_release: got stall %b ready %b exp 0 1", stall_o, ready_o); end
    next_cyc(); rs_valid = 3'b000;
  endtask

  task automatic test_err();
    next_cyc(); rvalid = 1'b1; rdata = 32'hdead_beef; #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before: got %b exp 0", err_o); end
    next_cyc(); rvalid = 1'b0; #1;
    checks++; if (err_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL err_set: got err %b wb %b exp 1 0", err_o, wb_valid_o); end
    next_cyc(); next_cyc(); #1;
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL err_sticky: got err %b busy %b exp 1 0", err_o, busy_o); end
  endtask

  task automatic test_reset_mid();
    next_cyc(); enable = 1'b1; waddr = 6'h21; gnt = 1'b0;
    next_cyc(); waddr = 6'h22; gnt = 1'b1;
    next_cyc(); enable = 1'b0; gnt = 1'b0; #1;
    checks++; if (busy_o !== 1'b1 || apu_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got busy %b req %b exp 1 1", busy_o, apu_req_o); end
    #1 rst_ni = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || apu_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_async: got busy %b req %b exp 0 0", busy_o, apu_req_o); end
    checks++; if (err_o !== 1'b0 || ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got err %b ready %b wb %b exp 0 1 0", err_o, ready_o, wb_valid_o); end
    next_cyc(); rst_ni = 1'b1;
    next_cyc(); rvalid = 1'b1;
    next_cyc(); rvalid = 1'b0; #1;
    checks++; if (err_o !== 1'b1 || wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_late_result: got err %b wb %b busy %b exp 1 0 0", err_o, wb_valid_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gnt_hold();
    test_back_to_back();
    test_hazard();
    test_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
